inst_encoder_writer: RTL and testbench

- LC-3b instruction encoder and memory writer: accepts decoded instruction fields (opcode, registers, offsets, mode bits) over a valid/ready handshake.
- Packs each set of fields into a 16-bit instruction word and buffers it in a small FIFO.
- Writes each buffered word to consecutive word addresses through the standard LC-3b memory port (write/resp handshake).
- Performs the inverse of instruction-register field extraction; used by the self-test program loader and as a bench program generator.

---
 rtl/inst_encoder_writer_if.sv | 29 ++
 rtl/inst_encoder_writer.sv | 71 +++++++
 tb/tb_inst_encoder_writer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_writer_if.sv
// inst_encoder_writer_if: decoded-field input handshake plus the LC-3b memory write port.
interface inst_encoder_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic [10:0] imm;
  logic        imm_enable;
  logic        d_enable;
  logic        jsr_enable;
  logic        addr_clear;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic        busy;
  logic [15:0] words_written;
  modport master (
    output in_valid, opcode, dest, src1, src2, imm, imm_enable, d_enable, jsr_enable, addr_clear, mem_resp,
    input  in_ready, mem_address, mem_wdata, mem_write, mem_byte_enable, busy, words_written
  );
  modport slave (
    input  in_valid, opcode, dest, src1, src2, imm, imm_enable, d_enable, jsr_enable, addr_clear, mem_resp,
    output in_ready, mem_address, mem_wdata, mem_write, mem_byte_enable, busy, words_written
  );
endinterface

// File: rtl/inst_encoder_writer.sv
// inst_encoder_writer: packs LC-3b instruction fields into words, queues them and writes them to memory.
module inst_encoder_writer #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input logic               clk,
  input logic               rst_n,
  inst_encoder_writer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t      state;
  logic [15:0] fifo [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [15:0] next_addr, word;
  logic        push, pop, launch;
  assign bus.in_ready        = count != (AW+1)'(DEPTH);
  assign bus.busy            = count != '0 || state == WRITE;
  assign bus.mem_byte_enable = 2'b11;
  assign push   = bus.in_valid && bus.in_ready;
  assign pop    = state == WRITE && bus.mem_resp;
  assign launch = state == IDLE && count != '0;
  always_comb begin
    word = {bus.opcode, 12'h000};
    case (bus.opcode)
      4'b0001, 4'b0101: word[11:0] = {bus.dest, bus.src1, bus.imm_enable,
                                      bus.imm_enable ? bus.imm[4:0] : {2'b00, bus.src2}};
      4'b1001: word[11:0] = {bus.dest, bus.src1, 6'h3F};
      4'b0000, 4'b1110: word[11:0] = {bus.dest, bus.imm[8:0]};
      4'b1100: word[11:0] = {3'b000, bus.src1, 6'h00};
      4'b0100: word[11:0] = bus.jsr_enable ? {1'b1, bus.imm} : {3'b000, bus.src1, 6'h00};
      4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1010, 4'b1011:
        word[11:0] = {bus.dest, bus.src1, bus.imm[5:0]};
      4'b1101: word[11:0] = {bus.dest, bus.src1, bus.imm_enable, bus.d_enable, bus.imm[3:0]};
      4'b1111: word[11:0] = {4'h0, bus.imm[7:0]};
      default: word[11:0] = 12'h000;
    endcase
  end
  always_ff @(posedge clk)
    if (push) fifo[wp] <= word;
  // The head stays in the FIFO while its write is in flight and is popped on mem_resp.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state             <= IDLE;
      wp                <= '0;
      rp                <= '0;
      count             <= '0;
      next_addr         <= BASE_ADDR;
      bus.mem_address   <= BASE_ADDR;
      bus.mem_wdata     <= '0;
      bus.mem_write     <= 1'b0;
      bus.words_written <= '0;
    end else begin
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (bus.addr_clear) next_addr <= launch ? BASE_ADDR + 16'd2 : BASE_ADDR;
      else if (launch) next_addr <= next_addr + 16'd2;
      if (launch) begin
        state           <= WRITE;
        bus.mem_write   <= 1'b1;
        bus.mem_address <= bus.addr_clear ? BASE_ADDR : next_addr;
        bus.mem_wdata   <= fifo[rp];
      end else if (pop) begin
        state             <= IDLE;
        bus.mem_write     <= 1'b0;
        bus.words_written <= bus.words_written + 16'd1;
      end
    end
endmodule

// File: tb/tb_inst_encoder_writer.sv
// tb_inst_encoder_writer: directed and randomized field sets scored against a field-arithmetic encoder model.
module tb_inst_encoder_writer;
  typedef struct {
    logic [3:0]  op;
    logic [2:0]  dest, src1, src2;
    logic [10:0] imm;
    logic        ie, de, je;
  } f_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hold = 1'b1;
  int          errors = 0;
  int          checks = 0;
  int          wait_cnt = 0;
  logic [15:0] exp_addr = 16'h0000;
  logic [15:0] ww_exp = 16'h0000;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  inst_encoder_writer_if bus();
  inst_encoder_writer #(.DEPTH(4), .BASE_ADDR(16'h0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // Memory model: random latency, records each completed write, stray resp pulses while idle.
  always @(negedge clk) begin
    bus.mem_resp = 1'b0;
    if (!hold && rst_n) begin
      if (bus.mem_write) begin
        if (wait_cnt == 0) begin
          bus.mem_resp = 1'b1;
          obs_q.push_back({bus.mem_address, bus.mem_wdata});
          wait_cnt = $urandom_range(0, 2);
        end else wait_cnt--;
      end else bus.mem_resp = ($urandom_range(0, 3) == 0);
    end
  end
  function automatic f_t mk(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                            input logic [2:0] s2, input logic [10:0] imm, input logic ie,
                            input logic de, input logic je);
    f_t f;
    f.op = op; f.dest = d; f.src1 = s1; f.src2 = s2; f.imm = imm; f.ie = ie; f.de = de; f.je = je;
    return f;
  endfunction
  function automatic f_t rnd();
    return mk(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 11'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
  endfunction
  function automatic logic [15:0] ref_enc(input f_t f);
    int r, w;
    r = int'(f.dest) * 512 + int'(f.src1) * 64;
    w = int'(f.op) * 4096;
    case (f.op)
      4'h1, 4'h5: w += r + (f.ie ? 32 + int'(f.imm) % 32 : int'(f.src2));
      4'h9: w += r + 63;
      4'h0, 4'hE: w += int'(f.dest) * 512 + int'(f.imm) % 512;
      4'hC: w += int'(f.src1) * 64;
      4'h4: w += f.je ? 2048 + int'(f.imm) : int'(f.src1) * 64;
      4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB: w += r + int'(f.imm) % 64;
      4'hD: w += r + int'(f.ie) * 32 + int'(f.de) * 16 + int'(f.imm) % 16;
      4'hF: w += int'(f.imm) % 256;
      default: ;
    endcase
    return w[15:0];
  endfunction
  task automatic push(input f_t f, input logic [15:0] w);
    int n = 0;
    bus.opcode = f.op; bus.dest = f.dest; bus.src1 = f.src1; bus.src2 = f.src2;
    bus.imm = f.imm; bus.imm_enable = f.ie; bus.d_enable = f.de; bus.jsr_enable = f.je;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL push_timeout in_ready=%b required 1", bus.in_ready);
    end
    exp_q.push_back({exp_addr, w});
    exp_addr += 16'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (bus.busy && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++;
    if (n >= 500) begin errors++; $display("FAIL %s_drain busy=%b required 0", name, bus.busy); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_count writes=%0d required %0d", name, obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      logic [31:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx;
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_write%0d addr/data=%h/%h required %h/%h", name, i, o[31:16], o[15:0],
                 exp_q[i][31:16], exp_q[i][15:0]);
      end
    end
    ww_exp += 16'(exp_q.size());
    checks++;
    if (bus.words_written !== ww_exp) begin
      errors++; $display("FAIL %s_words_written got=%0d required %0d", name, bus.words_written, ww_exp);
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    exp_addr = 16'h0000; ww_exp = 16'h0000;
  endtask
  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%b required 0", bus.mem_write); end
    checks++; if (bus.mem_address !== 16'h0000) begin errors++; $display("FAIL reset_mem_address got=%h required 0000", bus.mem_address); end
    checks++; if (bus.mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata got=%h required 0000", bus.mem_wdata); end
    checks++; if (bus.words_written !== 16'h0000) begin errors++; $display("FAIL reset_words_written got=%h required 0000", bus.words_written); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required 1", bus.in_ready); end
    checks++; if (bus.mem_byte_enable !== 2'b11) begin errors++; $display("FAIL reset_byte_enable got=%b required 11", bus.mem_byte_enable); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_add;
    hold = 1'b0;
    push(mk(4'h1, 3'd1, 3'd2, 3'd0, 11'h7FD, 1'b1, 1'b0, 1'b0), 16'h12BD);
    checks++;
    if (bus.mem_byte_enable !== 2'b11) begin errors++; $display("FAIL add_byte_enable got=%b required 11", bus.mem_byte_enable); end
    drain("add");
  endtask
  task automatic test_back_to_back;
    do_reset();
    push(mk(4'h5, 3'd3, 3'd4, 3'd5, 11'h7FF, 1'b0, 1'b0, 1'b0), 16'h5705);
    push(mk(4'h9, 3'd0, 3'd7, 3'd3, 11'h555, 1'b1, 1'b1, 1'b1), 16'h91FF);
    push(mk(4'hF, 3'd7, 3'd7, 3'd7, 11'h725, 1'b1, 1'b1, 1'b1), 16'hF025);
    push(mk(4'h0, 3'd7, 3'd0, 3'd0, 11'h1FF, 1'b0, 1'b0, 1'b0), 16'h0FFF);
    drain("back_to_back");
  endtask
  task automatic test_encodings;
    push(mk(4'hD, 3'd2, 3'd3, 3'd7, 11'h004, 1'b1, 1'b1, 1'b0), 16'hD4F4);
    push(mk(4'h6, 3'd1, 3'd2, 3'd0, 11'h003, 1'b0, 1'b0, 1'b0), 16'h6283);
    push(mk(4'h4, 3'd0, 3'd0, 3'd0, 11'h010, 1'b0, 1'b0, 1'b1), 16'h4810);
    push(mk(4'h4, 3'd7, 3'd5, 3'd7, 11'h7FF, 1'b1, 1'b1, 1'b0), 16'h4140);
    push(mk(4'h8, 3'd7, 3'd7, 3'd7, 11'h7FF, 1'b1, 1'b1, 1'b1), 16'h8000);
    push(mk(4'hC, 3'd7, 3'd6, 3'd7, 11'h7FF, 1'b1, 1'b1, 1'b1), 16'hC180);
    drain("encodings");
  endtask
  task automatic test_full;
    logic [15:0] a0, d0;
    f_t f;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin f = rnd(); push(f, ref_enc(f)); end
    a0 = bus.mem_address;
    d0 = bus.mem_wdata;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b required 0", bus.in_ready); end
    checks++;
    if (bus.mem_write !== 1'b1 || {a0, d0} !== exp_q[0]) begin
      errors++; $display("FAIL full_head write=%b addr/data=%h/%h required 1 %h", bus.mem_write, a0, d0, exp_q[0]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_write !== 1'b1 || bus.mem_address !== a0 || bus.mem_wdata !== d0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_stable cycle=%0d write/addr/data/ready=%b/%h/%h/%b required 1/%h/%h/0",
                 i, bus.mem_write, bus.mem_address, bus.mem_wdata, bus.in_ready, a0, d0);
      end
    end
    fork begin repeat (3) @(negedge clk); hold = 1'b0; end join_none
    f = rnd();
    push(f, ref_enc(f));
    drain("full");
  endtask
  task automatic test_random;
    f_t f;
    for (int i = 0; i < 40; i++) begin
      f = rnd();
      push(f, ref_enc(f));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain("random");
  endtask
  task automatic test_addr_clear;
    f_t f;
    int n = 0;
    do_reset();
    for (int i = 0; i < 2; i++) begin f = rnd(); push(f, ref_enc(f)); end
    drain("pre_clear");
    hold = 1'b1;
    f = rnd();
    push(f, ref_enc(f));
    while (!bus.mem_write && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_address !== 16'h0004) begin
      errors++; $display("FAIL clear_inflight write/addr=%b/%h required 1/0004", bus.mem_write, bus.mem_address);
    end
    bus.addr_clear = 1'b1;
    @(negedge clk);
    bus.addr_clear = 1'b0;
    exp_addr = 16'h0000;
    hold = 1'b0;
    f = rnd();
    push(f, ref_enc(f));
    drain("addr_clear");
  endtask
  task automatic test_reset_mid_write;
    f_t f;
    int n = 0;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin f = rnd(); push(f, ref_enc(f)); end
    while (!bus.mem_write && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.mem_write !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre write/busy=%b/%b required 1/1", bus.mem_write, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL midrst_mem_write got=%b required 0", bus.mem_write); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b required 0", bus.busy); end
    checks++; if (bus.words_written !== 16'h0000) begin errors++; $display("FAIL midrst_words_written got=%h required 0000", bus.words_written); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b required 1", bus.in_ready); end
    checks++; if (bus.mem_address !== 16'h0000) begin errors++; $display("FAIL midrst_mem_address got=%h required 0000", bus.mem_address); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    exp_addr = 16'h0000; ww_exp = 16'h0000;
    hold = 1'b0;
    f = rnd();
    push(f, ref_enc(f));
    drain("after_reset");
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.addr_clear = 1'b0; bus.opcode = '0; bus.dest = '0; bus.src1 = '0;
    bus.src2 = '0; bus.imm = '0; bus.imm_enable = 1'b0; bus.d_enable = 1'b0; bus.jsr_enable = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_encodings();
    test_full();
    test_random();
    test_addr_clear();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
